// File: rtl/delay_ctrl_pkg.sv
// ============================================================================
// Module : delay_ctrl_pkg
// Brief  : Shared controller state encoding and counter width for delay_ctrl.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package delay_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam int DROP_CNT_W = 16;

endpackage : delay_ctrl_pkg

`default_nettype wire

// File: rtl/ram2ports.sv
// ============================================================================
// Module : ram2ports
// Brief  : Simple dual-port RAM, synchronous write, registered read with enable.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram2ports #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] r_rd_data;

  // Storage array carries no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data <= '0;
    end else if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule : ram2ports

`default_nettype wire

// File: rtl/delay_ctrl.sv
// ============================================================================
// Module : delay_ctrl
// Brief  : Programmable sample delay line with valid/ready handshakes.
//          Optional stall counter enabled by macro DELAY_CTRL_DROP_CNT_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module delay_ctrl
  import delay_ctrl_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 9,
  parameter int DATA_WIDTH    = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     stop,
  input  logic [ADDRESS_WIDTH-1:0] delay,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [DATA_WIDTH-1:0]    din,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [DATA_WIDTH-1:0]    dout,
  output logic                     busy
`ifdef DELAY_CTRL_DROP_CNT_EN
  ,
  output logic [DROP_CNT_W-1:0]    drop_cnt
`endif
);

  localparam logic [ADDRESS_WIDTH-1:0] c_ONE = 1;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [ADDRESS_WIDTH-1:0] r_wr_ptr;
  logic [ADDRESS_WIDTH-1:0] r_fill_cnt;
  logic [ADDRESS_WIDTH-1:0] r_dly;
  logic                     r_m_valid;
  logic                     w_s_ready;
  logic                     w_accept;
  logic                     w_start_go;
  logic                     w_wr_en;
  logic                     w_rd_en;
  logic [ADDRESS_WIDTH-1:0] w_fill_inc;
  logic [ADDRESS_WIDTH-1:0] w_rd_addr;
  logic [DATA_WIDTH-1:0]    w_rd_data;

  assign w_s_ready  = (r_state == FILL) || ((r_state == RUN) && (!r_m_valid || m_ready));
  assign w_accept   = s_valid && w_s_ready;
  assign w_fill_inc = r_fill_cnt + c_ONE;

  // A stopped cycle must not touch the buffer or produce output.
  assign w_wr_en    = w_accept && !stop;
  assign w_rd_en    = w_accept && !stop && (r_state == RUN);
  assign w_rd_addr  = r_wr_ptr - r_dly;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start_go  = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_start_go  = 1'b1;
          w_state_nxt = FILL;
        end
      end
      FILL: begin
        if (w_accept && (w_fill_inc == r_dly)) begin
          w_state_nxt = RUN;
        end
      end
      RUN:     w_state_nxt = RUN;
      default: w_state_nxt = IDLE;
    endcase
    if (stop) begin
      w_start_go  = 1'b0;
      w_state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_fill_cnt <= '0;
      r_dly      <= c_ONE;
      r_m_valid  <= 1'b0;
    end else if (stop) begin
      r_m_valid  <= 1'b0;
    end else if (w_start_go) begin
      r_wr_ptr   <= '0;
      r_fill_cnt <= '0;
      r_dly      <= (delay == '0) ? c_ONE : delay;
    end else begin
      if (w_accept) begin
        r_wr_ptr <= r_wr_ptr + c_ONE;
      end
      if (w_accept && (r_state == FILL)) begin
        r_fill_cnt <= w_fill_inc;
      end
      if (w_rd_en) begin
        r_m_valid <= 1'b1;
      end else if (m_ready) begin
        r_m_valid <= 1'b0;
      end
    end
  end

  ram2ports #(
    .ADDR_W (ADDRESS_WIDTH),
    .DATA_W (DATA_WIDTH)
  ) u_ram (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (din),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_rd_data)
  );

`ifdef DELAY_CTRL_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] r_drop_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop_cnt <= '0;
    end else if (w_start_go) begin
      r_drop_cnt <= '0;
    end else if ((r_state == RUN) && s_valid && !w_s_ready && (r_drop_cnt != '1)) begin
      r_drop_cnt <= r_drop_cnt + 1'b1;
    end
  end

  assign drop_cnt = r_drop_cnt;
`endif

  assign s_ready = w_s_ready;
  assign m_valid = r_m_valid;
  assign dout    = w_rd_data;
  assign busy    = (r_state != IDLE);

endmodule : delay_ctrl

`default_nettype wire

// File: tb/tb_delay_ctrl.sv
// ============================================================================
// Module : tb_delay_ctrl
// Brief  : Directed self-checking bench for delay_ctrl (default and 4-bit address builds).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_delay_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [8:0] delay = '0;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic [7:0] din = '0;
  logic       m_valid;
  logic       m_ready = 1'b0;
  logic [7:0] dout;
  logic       busy;
`ifdef DELAY_CTRL_DROP_CNT_EN
  logic [15:0] drop_cnt;
  logic [15:0] d4_drop_cnt;
`endif

  logic       d4_start = 1'b0;
  logic       d4_stop = 1'b0;
  logic [3:0] d4_delay = '0;
  logic       d4_s_valid = 1'b0;
  logic       d4_s_ready;
  logic [7:0] d4_din = '0;
  logic       d4_m_valid;
  logic       d4_m_ready = 1'b0;
  logic [7:0] d4_dout;
  logic       d4_busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  delay_ctrl u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .stop     (stop),
    .delay    (delay),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .din      (din),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .dout     (dout),
    .busy     (busy)
`ifdef DELAY_CTRL_DROP_CNT_EN
    ,
    .drop_cnt (drop_cnt)
`endif
  );

  delay_ctrl #(.ADDRESS_WIDTH(4), .DATA_WIDTH(8)) u_dut4 (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (d4_start),
    .stop     (d4_stop),
    .delay    (d4_delay),
    .s_valid  (d4_s_valid),
    .s_ready  (d4_s_ready),
    .din      (d4_din),
    .m_valid  (d4_m_valid),
    .m_ready  (d4_m_ready),
    .dout     (d4_dout),
    .busy     (d4_busy)
`ifdef DELAY_CTRL_DROP_CNT_EN
    ,
    .drop_cnt (d4_drop_cnt)
`endif
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [8:0] d);
    delay = d;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic do_stop;
    s_valid = 1'b0;
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic test_reset;
    #1 rst_n = 1'b0;
    #2;
    n_checks++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL reset_s_ready: got %b want 0", s_ready); end
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid: got %b want 0", m_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (dout !== 8'h00) begin n_fail++; $display("FAIL reset_dout: got %h want 00", dout); end
`ifdef DELAY_CTRL_DROP_CNT_EN
    n_checks++; if (drop_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_drop_cnt: got %h want 0", drop_cnt); end
`endif
    step();
    step();
    rst_n = 1'b1;
    step();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_delay3;
    do_start(9'd3);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL d3_busy: got %b want 1", busy); end
    n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL d3_fill_ready: got %b want 1", s_ready); end
    m_ready = 1'b1;
    s_valid = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      din = 8'(n);
      step();
      n_checks++;
      if (m_valid !== (n >= 4)) begin n_fail++; $display("FAIL d3_m_valid[%0d]: got %b want %b", n, m_valid, (n >= 4)); end
      if (n >= 4) begin
        n_checks++;
        if (dout !== 8'(n - 3)) begin n_fail++; $display("FAIL d3_dout[%0d]: got %0d want %0d", n, dout, n - 3); end
      end
    end
    s_valid = 1'b0;
    step();
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL d3_valid_clear: got %b want 0", m_valid); end
    do_stop();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL d3_stop_busy: got %b want 0", busy); end
  endtask

  task automatic test_delay0;
    logic [7:0] vals [3];
    vals[0] = 8'd10; vals[1] = 8'd20; vals[2] = 8'd30;
    do_start(9'd0);
    m_ready = 1'b1;
    s_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      din = vals[i];
      step();
      n_checks++;
      if (m_valid !== (i >= 1)) begin n_fail++; $display("FAIL d0_m_valid[%0d]: got %b want %b", i, m_valid, (i >= 1)); end
      if (i >= 1) begin
        n_checks++;
        if (dout !== vals[i-1]) begin n_fail++; $display("FAIL d0_dout[%0d]: got %0d want %0d", i, dout, vals[i-1]); end
      end
    end
    do_stop();
  endtask

  task automatic test_backpressure;
    do_start(9'd2);
    m_ready = 1'b1;
    s_valid = 1'b1;
    for (int n = 1; n <= 3; n++) begin
      din = 8'(n);
      step();
    end
    n_checks++; if (m_valid !== 1'b1 || dout !== 8'd1) begin n_fail++; $display("FAIL bp_first: got v=%b d=%0d want v=1 d=1", m_valid, dout); end
    m_ready = 1'b0;
    din = 8'd4;
    #1;
    n_checks++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL bp_s_ready_low: got %b want 0", s_ready); end
    for (int c = 0; c < 4; c++) begin
      step();
      n_checks++;
      if (m_valid !== 1'b1 || dout !== 8'd1 || s_ready !== 1'b0) begin
        n_fail++; $display("FAIL bp_hold[%0d]: got v=%b d=%0d r=%b want v=1 d=1 r=0", c, m_valid, dout, s_ready);
      end
    end
    m_ready = 1'b1;
    #1;
    n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL bp_s_ready_release: got %b want 1", s_ready); end
    step();
    n_checks++; if (m_valid !== 1'b1 || dout !== 8'd2) begin n_fail++; $display("FAIL bp_after_release: got v=%b d=%0d want v=1 d=2", m_valid, dout); end
    din = 8'd5;
    step();
    n_checks++; if (dout !== 8'd3) begin n_fail++; $display("FAIL bp_next: got %0d want 3", dout); end
    // start and a new delay while running must be ignored
    din = 8'd6;
    delay = 9'd7;
    start = 1'b1;
    step();
    start = 1'b0;
    n_checks++; if (dout !== 8'd4 || busy !== 1'b1) begin n_fail++; $display("FAIL bp_start_ignored: got d=%0d b=%b want d=4 b=1", dout, busy); end
    din = 8'd7;
    step();
    n_checks++; if (dout !== 8'd5) begin n_fail++; $display("FAIL bp_delay_ignored: got %0d want 5", dout); end
    do_stop();
  endtask

  task automatic test_stop;
    do_start(9'd2);
    m_ready = 1'b1;
    s_valid = 1'b1;
    for (int n = 1; n <= 3; n++) begin
      din = 8'(n);
      step();
    end
    n_checks++; if (m_valid !== 1'b1 || dout !== 8'd1) begin n_fail++; $display("FAIL stop_pre: got v=%b d=%0d want v=1 d=1", m_valid, dout); end
    din = 8'd4;
    stop = 1'b1;
    start = 1'b1;
    step();
    stop = 1'b0;
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || m_valid !== 1'b0 || s_ready !== 1'b0) begin
      n_fail++; $display("FAIL stop_run: got b=%b v=%b r=%b want 0 0 0", busy, m_valid, s_ready);
    end
    // stop wins over start in IDLE
    stop = 1'b1;
    start = 1'b1;
    step();
    stop = 1'b0;
    start = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL stop_over_start: got %b want 0", busy); end
    do_start(9'd2);
    for (int n = 7; n <= 9; n++) begin
      din = 8'(n);
      step();
      n_checks++;
      if (m_valid !== (n == 9)) begin n_fail++; $display("FAIL refill_valid[%0d]: got %b want %b", n, m_valid, (n == 9)); end
    end
    n_checks++; if (dout !== 8'd7) begin n_fail++; $display("FAIL refill_dout: got %0d want 7", dout); end
    do_stop();
  endtask

  task automatic test_wrap;
    d4_delay = 4'd15;
    d4_start = 1'b1;
    step();
    d4_start = 1'b0;
    d4_m_ready = 1'b1;
    d4_s_valid = 1'b1;
    for (int k = 0; k < 40; k++) begin
      d4_din = 8'(k * 7 + 3);
      step();
      n_checks++;
      if (d4_m_valid !== (k >= 15)) begin n_fail++; $display("FAIL wrap_valid[%0d]: got %b want %b", k, d4_m_valid, (k >= 15)); end
      if (k >= 15) begin
        n_checks++;
        if (d4_dout !== 8'((k - 15) * 7 + 3)) begin
          n_fail++; $display("FAIL wrap_dout[%0d]: got %0d want %0d", k, d4_dout, 8'((k - 15) * 7 + 3));
        end
      end
    end
    d4_s_valid = 1'b0;
    d4_stop = 1'b1;
    step();
    d4_stop = 1'b0;
  endtask

  task automatic test_reset_mid_run;
    do_start(9'd2);
    m_ready = 1'b1;
    s_valid = 1'b1;
    for (int n = 1; n <= 3; n++) begin
      din = 8'(n + 40);
      step();
    end
    n_checks++; if (m_valid !== 1'b1 || dout !== 8'd41) begin n_fail++; $display("FAIL rmid_pre: got v=%b d=%0d want v=1 d=41", m_valid, dout); end
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (m_valid !== 1'b0 || busy !== 1'b0 || s_ready !== 1'b0 || dout !== 8'h00) begin
      n_fail++; $display("FAIL rmid_async: got v=%b b=%b r=%b d=%h want 0 0 0 00", m_valid, busy, s_ready, dout);
    end
    s_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

`ifdef DELAY_CTRL_DROP_CNT_EN
  task automatic test_drop_cnt;
    do_start(9'd1);
    m_ready = 1'b1;
    s_valid = 1'b1;
    din = 8'd1;
    step();
    din = 8'd2;
    step();
    m_ready = 1'b0;
    for (int c = 0; c < 5; c++) step();
    n_checks++; if (drop_cnt !== 16'd5) begin n_fail++; $display("FAIL drop_cnt_5: got %0d want 5", drop_cnt); end
    n_checks++; if (m_valid !== 1'b1 || dout !== 8'd1) begin n_fail++; $display("FAIL drop_hold: got v=%b d=%0d want v=1 d=1", m_valid, dout); end
    m_ready = 1'b1;
    do_stop();
    do_start(9'd1);
    n_checks++; if (drop_cnt !== 16'd0) begin n_fail++; $display("FAIL drop_clear: got %0d want 0", drop_cnt); end
    do_stop();
  endtask
`endif

  initial begin
    test_reset();
    test_delay3();
    test_delay0();
    test_backpressure();
    test_stop();
    test_wrap();
    test_reset_mid_run();
`ifdef DELAY_CTRL_DROP_CNT_EN
    test_drop_cnt();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_delay_ctrl

`default_nettype wire

// File: doc/delay_ctrl.md
DELAY_CTRL -- requirements
Module: delay_ctrl

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 9, buffer address width (depth 2**ADDRESS_WIDTH).
REQ-002 SHALL have parameter DATA_WIDTH, default 8, sample width.
REQ-003 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  in  1  one-cycle pulse that begins operation.
REQ-006 SHALL have port stop  in  1  one-cycle pulse that aborts to IDLE.
REQ-007 SHALL have port delay  in  ADDRESS_WIDTH  requested delay in samples.
REQ-008 SHALL have port s_valid / s_ready  in / out  1 / 1  input sample handshake.
REQ-009 SHALL have port din  in  DATA_WIDTH  input sample.
REQ-010 SHALL have port m_valid / m_ready  out / in  1 / 1  output sample handshake.
REQ-011 SHALL have port dout  out  DATA_WIDTH  delayed sample.
REQ-012 SHALL have port busy  out  1  high whenever state != IDLE.

Function
REQ-013 SHALL implement FSM IDLE, FILL, RUN; an input sample is accepted on a cycle with s_valid && s_ready.
REQ-014 SHALL, in IDLE on start, latch delay as dly (0 is latched as 1), clear wr_ptr and fill count, and go to FILL; start outside IDLE is ignored.
REQ-015 SHALL drive s_ready = 1 in FILL, (!m_valid || m_ready) in RUN, and 0 in IDLE.
REQ-016 SHALL, on every accept, write din at wr_ptr and increment wr_ptr modulo 2**ADDRESS_WIDTH.
REQ-017 SHALL, in FILL, count accepts and go to RUN on the accept that makes the count equal to dly; no output is produced in FILL.
REQ-018 SHALL, on each accept in RUN, read address (wr_ptr - dly) mod 2**ADDRESS_WIDTH with the pre-increment wr_ptr; dout and m_valid update at the same edge, giving 1-cycle latency.
REQ-019 SHALL make output sample k equal input sample k-dly; the read address never equals the write address, because dly >= 1.
REQ-020 SHALL hold dout and m_valid stable while m_valid && !m_ready, and clear m_valid on m_ready when there is no new accept.
REQ-021 SHALL sustain 1 sample/cycle in RUN with m_ready held high, including the simultaneous m_ready-and-accept case.
REQ-022 SHALL, on stop in any state, enter IDLE at the next edge, clear m_valid and discard buffered data; stop has priority over start and over an accept in the same cycle.
REQ-023 SHALL ignore changes on delay except at a start accepted in IDLE.

Reset
REQ-024 SHALL, while rst_n is low, asynchronously force state=IDLE, wr_ptr=0, fill count=0, dly=1, m_valid=0, s_ready=0, busy=0, dout=0.
REQ-025 SHALL leave RAM contents undefined after reset; no output may depend on them before refill.

Configuration
REQ-026 SHALL, with macro DELAY_CTRL_DROP_CNT_EN defined, add output drop_cnt[15:0], which counts cycles in RUN with s_valid && !s_ready, saturates at 16'hFFFF and clears on start and on reset.
REQ-027 SHALL, without DELAY_CTRL_DROP_CNT_EN, omit the drop_cnt port and its logic; all other behaviour is identical.

Structure
REQ-028 SHALL place the state enum typedef (IDLE/FILL/RUN) and localparam DROP_CNT_W=16 in package delay_ctrl_pkg.
REQ-029 SHALL instantiate the team's dual-port RAM, ram2ports, as the sole sub-module (synchronous write, registered read with rd_en), with controller logic in delay_ctrl.

Verification
REQ-030 SHALL cover this case: delay=3, start, inputs 1..8 with m_ready=1 -> m_valid first high one cycle after input 4 is accepted; outputs are 1,2,3,4,5.
REQ-031 SHALL cover this case: delay=0, start, inputs 10,20,30 -> behaves as delay=1; outputs 10,20 each one cycle after the following accept.
REQ-032 SHALL cover this case: delay=2 in RUN, m_ready low for 4 cycles -> s_ready=0, and dout/m_valid stay stable; on release the next output follows without loss or duplication.
REQ-033 SHALL cover this case: ADDRESS_WIDTH=4, delay=15, stream 40 samples -> output k equals input k-15 across pointer wrap-around.
REQ-034 SHALL cover this case: stop asserted in RUN with m_valid=1 and a concurrent accept -> next cycle state=IDLE, m_valid=0, busy=0; a following start with delay=2 refills from scratch.
REQ-035 SHALL cover this case: rst_n low mid-RUN -> all outputs reset immediately; with DELAY_CTRL_DROP_CNT_EN, 5 stalled s_valid cycles in RUN give drop_cnt=5.
